spr_nested: RTL

- Parametrised special-purpose register file for the MIPS core. Successor to the flat SPR block.
- Adds a DEPTH-deep exception-context stack so nested interrupts keep every saved context.
- Adds an explicit rfe (return-from-exception) restore, an addressed SPR read/write port (movg2s/movs2g) and an overflow flag.
- Sits beside the GPR file in the execute/writeback stage. Driven by the interrupt unit (jisr, mca, rpt) and the decoder (rfe, we).

---
 rtl/spr_nested.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spr_nested.sv
// spr_nested: special-purpose register file with a nested exception-context stack.
// Live registers SR/ESR/ECA/EPC/EDATA/PTO/PTL/MODE plus DEPTH-1 shadow contexts
// {ESR,ECA,EPC,EDATA,EMODE} so nested exceptions keep every saved context.
// Optional feature macro: SPR_READ_BYPASS_EN (same-cycle write-to-read forwarding on rd).
module spr_nested #(
    parameter int DW    = 32,
    parameter int MCA_W = 23,
    parameter int DEPTH = 4,
    parameter int DPW   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           jisr,
    input  logic [MCA_W-1:0] mca,
    input  logic           rpt,
    input  logic [DW-1:0]  pc,
    input  logic [DW-1:0]  next_pc,
    input  logic [DW-1:0]  ea,
    input  logic           rfe,
    input  logic           we,
    input  logic [2:0]     wa,
    input  logic [DW-1:0]  wd,
    input  logic [2:0]     ra,
    output logic [DW-1:0]  rd,
    output logic [DW-1:0]  sr_out,
    output logic [DW-1:0]  esr_out,
    output logic [DW-1:0]  eca_out,
    output logic [DW-1:0]  epc_out,
    output logic [DW-1:0]  edata_out,
    output logic [DW-1:0]  pto,
    output logic [DW-1:0]  ptl,
    output logic           mode_out,
    output logic [DPW-1:0] depth_out,
    output logic           ovf
);

    // One saved exception context; the live E-registers use the same layout.
    typedef struct packed {
        logic [DW-1:0] esr;
        logic [DW-1:0] eca;
        logic [DW-1:0] epc;
        logic [DW-1:0] edata;
        logic          emode;
    } ctx_t;

    localparam logic [DPW-1:0] DEPTH_C = DPW'(DEPTH);

    logic [DW-1:0]  sr_q, sr_d;
    logic [DW-1:0]  pto_q, pto_d;
    logic [DW-1:0]  ptl_q, ptl_d;
    logic           mode_q, mode_d;
    logic [DPW-1:0] depth_q, depth_d;
    logic           ovf_q, ovf_d;
    ctx_t           ctx_q, ctx_d;
    ctx_t           shadow_q [DEPTH-1];
    ctx_t           shadow_d [DEPTH-1];

    // Next-state: jisr wins over rfe, rfe over software writes; losers are dropped.
    always_comb begin
        sr_d     = sr_q;
        pto_d    = pto_q;
        ptl_d    = ptl_q;
        mode_d   = mode_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        ctx_d    = ctx_q;
        shadow_d = shadow_q;
        if (jisr) begin
            // Live E-regs only hold a valid context once depth>=1; at full depth the
            // top is overwritten instead of pushed.
            if (depth_q != '0 && depth_q < DEPTH_C) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (depth_q == DPW'(i + 1)) shadow_d[i] = ctx_q;
                end
            end
            ctx_d.esr   = sr_q;
            ctx_d.eca   = {{(DW - MCA_W){1'b0}}, mca};
            ctx_d.epc   = rpt ? pc : next_pc;
            ctx_d.edata = ea;
            ctx_d.emode = mode_q;
            sr_d        = '0;
            mode_d      = 1'b0;
            if (depth_q < DEPTH_C) depth_d = depth_q + DPW'(1);
            else                   ovf_d   = 1'b1;
        end else if (rfe) begin
            sr_d   = ctx_q.esr;
            mode_d = ctx_q.emode;
            if (depth_q >= DPW'(2)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (depth_q == DPW'(i + 2)) ctx_d = shadow_q[i];
                end
                depth_d = depth_q - DPW'(1);
            end else begin
                // depth 1 drops to 0 keeping E-regs; depth 0 stays 0 silently.
                depth_d = '0;
            end
        end else if (we) begin
            case (wa)
                3'd0:    sr_d        = wd;
                3'd1:    ctx_d.esr   = wd;
                3'd2:    ctx_d.eca   = wd;
                3'd3:    ctx_d.epc   = wd;
                3'd4:    ctx_d.edata = wd;
                3'd5:    pto_d       = wd;
                3'd6:    ptl_d       = wd;
                default: mode_d      = wd[0];
            endcase
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            pto_q   <= '0;
            ptl_q   <= '0;
            mode_q  <= 1'b0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            ctx_q   <= '0;
            for (int i = 0; i < DEPTH - 1; i++) shadow_q[i] <= '0;
        end else begin
            sr_q     <= sr_d;
            pto_q    <= pto_d;
            ptl_q    <= ptl_d;
            mode_q   <= mode_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
            ctx_q    <= ctx_d;
            shadow_q <= shadow_d;
        end
    end

    // Read port: registered value, optionally forwarded from a same-cycle write.
    always_comb begin
        case (ra)
            3'd0:    rd = sr_q;
            3'd1:    rd = ctx_q.esr;
            3'd2:    rd = ctx_q.eca;
            3'd3:    rd = ctx_q.epc;
            3'd4:    rd = ctx_q.edata;
            3'd5:    rd = pto_q;
            3'd6:    rd = ptl_q;
            default: rd = {{(DW - 2){1'b0}}, ctx_q.emode, mode_q};
        endcase
`ifdef SPR_READ_BYPASS_EN
        if (we && !jisr && !rfe && wa == ra) begin
            if (ra == 3'd7) rd = {{(DW - 2){1'b0}}, ctx_q.emode, wd[0]};
            else            rd = wd;
        end
`endif
    end

    assign sr_out    = sr_q;
    assign esr_out   = ctx_q.esr;
    assign eca_out   = ctx_q.eca;
    assign epc_out   = ctx_q.epc;
    assign edata_out = ctx_q.edata;
    assign pto       = pto_q;
    assign ptl       = ptl_q;
    assign mode_out  = mode_q;
    assign depth_out = depth_q;
    assign ovf       = ovf_q;

endmodule
